// File: rtl/p3_execute.sv
// Execute stage of the P3 pipeline: ALU, flag register, branch resolution,
// output port, halt latch and a one-slot squash after a taken branch.
module p3_execute (
  input  logic        clockp3,
  input  logic        reset,
  input  logic        validin,
  input  logic [15:0] alu1,
  input  logic [15:0] alu2,
  input  logic [3:0]  opcode,
  input  logic        writereg,
  input  logic [1:0]  memwrite,
  input  logic [2:0]  regaddress,
  input  logic [15:0] address,
  input  logic [15:0] storedata,
  input  logic        isbranch,
  input  logic [2:0]  cond,
  input  logic [15:0] pcin,
  input  logic        haltin,
  output logic        validout,
  output logic [15:0] aluresult,
  output logic        writeregout,
  output logic [1:0]  memwriteout,
  output logic [2:0]  regaddressout,
  output logic [15:0] addressout,
  output logic [15:0] storedataout,
  output logic        branchtaken,
  output logic [15:0] branchtarget,
  output logic [3:0]  flags,
  output logic [15:0] outport,
  output logic        outvalid,
  output logic        haltout
);

  // Set for exactly one cycle after a taken branch so the wrong-path
  // instruction that follows it is dropped.
  logic        squash;

  logic        accept;
  logic        taken;
  logic [15:0] res;
  logic [3:0]  nflags;
  logic        flagupd;

  logic [16:0] sum;
  logic [15:0] diff;
  logic [31:0] lsh;
  logic [16:0] rsh;
  logic [16:0] ash;

  // An input is taken only when the stage is live and not draining a branch.
  always_comb begin
    accept = validin & ~haltout & ~squash & ~reset;
  end

  // Branch condition uses the flags as they stood before this edge.
  always_comb begin
    taken = 1'b0;
    case (cond)
      3'd0: taken = flags[2];
      3'd1: taken = flags[3] ^ flags[0];
      3'd2: taken = flags[2] | (flags[3] ^ flags[0]);
      3'd3: taken = ~flags[2];
      3'd4: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // ALU datapath and the candidate flag value {S,Z,C,V}; shifts are done in
  // widened vectors so the bit shifted out lands in a fixed position.
  always_comb begin
    sum     = {1'b0, alu1} + {1'b0, alu2};
    diff    = alu1 - alu2;
    lsh     = {16'b0, alu1} << alu2[3:0];
    rsh     = {alu1, 1'b0} >> alu2[3:0];
    ash     = $signed({alu1, 1'b0}) >>> alu2[3:0];
    res     = 16'h0000;
    nflags  = flags;
    flagupd = 1'b0;
    case (opcode)
      4'd0: begin
        res     = sum[15:0];
        flagupd = 1'b1;
        nflags  = {sum[15], sum[15:0] == 16'h0000, sum[16],
                   (alu1[15] == alu2[15]) && (sum[15] != alu1[15])};
      end
      4'd1, 4'd5: begin
        res     = (opcode == 4'd1) ? diff : 16'h0000;
        flagupd = 1'b1;
        nflags  = {diff[15], diff == 16'h0000, alu1 < alu2,
                   (alu1[15] != alu2[15]) && (diff[15] != alu1[15])};
      end
      4'd2, 4'd3, 4'd4, 4'd6: begin
        case (opcode)
          4'd2:    res = alu1 & alu2;
          4'd3:    res = alu1 | alu2;
          4'd4:    res = alu1 ^ alu2;
          default: res = alu1;
        endcase
        flagupd = 1'b1;
        nflags  = {res[15], res == 16'h0000, 1'b0, 1'b0};
      end
      4'd8, 4'd9: begin
        res     = (opcode == 4'd8) ? lsh[15:0] : (lsh[15:0] | lsh[31:16]);
        flagupd = 1'b1;
        nflags  = {res[15], res == 16'h0000, lsh[16], 1'b0};
      end
      4'd10: begin
        res     = rsh[16:1];
        flagupd = 1'b1;
        nflags  = {res[15], res == 16'h0000, rsh[0], 1'b0};
      end
      4'd11: begin
        res     = ash[16:1];
        flagupd = 1'b1;
        nflags  = {res[15], res == 16'h0000, ash[0], 1'b0};
      end
      default: begin
        res     = 16'h0000;
        flagupd = 1'b0;
      end
    endcase
  end

  // Pipeline register: accepted inputs produce results after this edge,
  // rejected edges emit a bubble with all side-effect strobes low.
  always_ff @(posedge clockp3) begin
    if (reset) begin
      validout      <= 1'b0;
      aluresult     <= 16'h0000;
      writeregout   <= 1'b0;
      memwriteout   <= 2'b00;
      regaddressout <= 3'd0;
      addressout    <= 16'h0000;
      storedataout  <= 16'h0000;
      branchtaken   <= 1'b0;
      branchtarget  <= 16'h0000;
      flags         <= 4'b0000;
      outport       <= 16'h0000;
      outvalid      <= 1'b0;
      haltout       <= 1'b0;
      squash        <= 1'b0;
    end else if (accept) begin
      validout      <= 1'b1;
      aluresult     <= res;
      writeregout   <= writereg;
      memwriteout   <= 2'b00;
      regaddressout <= regaddress;
      addressout    <= address;
      storedataout  <= storedata;
      branchtaken   <= 1'b0;
      outvalid      <= 1'b0;
      squash        <= 1'b0;
      if (haltin) begin
        haltout     <= 1'b1;
        writeregout <= 1'b0;
      end else if (isbranch) begin
        writeregout  <= 1'b0;
        branchtaken  <= taken;
        squash       <= taken;
        branchtarget <= pcin + address;
      end else if (memwrite != 2'b00) begin
        aluresult   <= 16'h0000;
        memwriteout <= memwrite;
      end else begin
        if (flagupd) begin
          flags <= nflags;
        end
        if (opcode == 4'd13) begin
          outport  <= alu1;
          outvalid <= 1'b1;
        end
      end
    end else begin
      validout    <= 1'b0;
      writeregout <= 1'b0;
      memwriteout <= 2'b00;
      branchtaken <= 1'b0;
      outvalid    <= 1'b0;
      squash      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_p3_execute.sv
// Directed bench for the P3 execute stage with hand-computed expectations.
module tb_p3_execute;

  logic        clockp3;
  logic        reset;
  logic        validin;
  logic [15:0] alu1;
  logic [15:0] alu2;
  logic [3:0]  opcode;
  logic        writereg;
  logic [1:0]  memwrite;
  logic [2:0]  regaddress;
  logic [15:0] address;
  logic [15:0] storedata;
  logic        isbranch;
  logic [2:0]  cond;
  logic [15:0] pcin;
  logic        haltin;
  logic        validout;
  logic [15:0] aluresult;
  logic        writeregout;
  logic [1:0]  memwriteout;
  logic [2:0]  regaddressout;
  logic [15:0] addressout;
  logic [15:0] storedataout;
  logic        branchtaken;
  logic [15:0] branchtarget;
  logic [3:0]  flags;
  logic [15:0] outport;
  logic        outvalid;
  logic        haltout;

  int tests;
  int failures;

  p3_execute dut (
    .clockp3(clockp3), .reset(reset), .validin(validin), .alu1(alu1),
    .alu2(alu2), .opcode(opcode), .writereg(writereg), .memwrite(memwrite),
    .regaddress(regaddress), .address(address), .storedata(storedata),
    .isbranch(isbranch), .cond(cond), .pcin(pcin), .haltin(haltin),
    .validout(validout), .aluresult(aluresult), .writeregout(writeregout),
    .memwriteout(memwriteout), .regaddressout(regaddressout),
    .addressout(addressout), .storedataout(storedataout),
    .branchtaken(branchtaken), .branchtarget(branchtarget), .flags(flags),
    .outport(outport), .outvalid(outvalid), .haltout(haltout)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clockp3 = 1'b0;
    forever #5 clockp3 = ~clockp3;
  end

  // Return every input to an idle, non-valid instruction.
  task automatic clearInputs();
    validin = 1'b0; alu1 = 16'h0; alu2 = 16'h0; opcode = 4'd0;
    writereg = 1'b0; memwrite = 2'b00; regaddress = 3'd0; address = 16'h0;
    storedata = 16'h0; isbranch = 1'b0; cond = 3'd0; pcin = 16'h0;
    haltin = 1'b0;
  endtask

  // Present a plain ALU instruction.
  task automatic setAlu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    clearInputs();
    validin = 1'b1; opcode = op; alu1 = a; alu2 = b; writereg = 1'b1;
  endtask

  // Let one rising edge pass, then settle before sampling.
  task automatic applyStimulus();
    @(posedge clockp3);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    failures = 0;
    clearInputs();
    reset = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_valid", {15'b0, validout}, 16'h0);
    checkOutput("rst_flags", {12'b0, flags}, 16'h0);
    checkOutput("rst_halt", {15'b0, haltout}, 16'h0);
    checkOutput("rst_outport", outport, 16'h0);
    checkOutput("rst_taken", {15'b0, branchtaken}, 16'h0);

    // ADD with signed overflow
    reset = 1'b0;
    setAlu(4'd0, 16'h7FFF, 16'h0001); regaddress = 3'd3;
    applyStimulus();
    checkOutput("add_res", aluresult, 16'h8000);
    checkOutput("add_flags", {12'b0, flags}, 16'h0009);
    checkOutput("add_wr", {15'b0, writeregout}, 16'h1);
    checkOutput("add_valid", {15'b0, validout}, 16'h1);
    checkOutput("add_rega", {13'b0, regaddressout}, 16'h3);

    // CMP equal operands, then branch on Z
    setAlu(4'd5, 16'h0003, 16'h0003); writereg = 1'b0;
    applyStimulus();
    checkOutput("cmp_res", aluresult, 16'h0);
    checkOutput("cmp_flags", {12'b0, flags}, 16'h0004);
    clearInputs();
    validin = 1'b1; isbranch = 1'b1; cond = 3'd0; address = 16'h0005; pcin = 16'h0010;
    applyStimulus();
    checkOutput("br_taken", {15'b0, branchtaken}, 16'h1);
    checkOutput("br_target", branchtarget, 16'h0015);
    checkOutput("br_wr", {15'b0, writeregout}, 16'h0);
    checkOutput("br_flags", {12'b0, flags}, 16'h0004);

    // Instruction right after the taken branch is squashed
    setAlu(4'd0, 16'h0001, 16'h0001);
    applyStimulus();
    checkOutput("sq_valid", {15'b0, validout}, 16'h0);
    checkOutput("sq_wr", {15'b0, writeregout}, 16'h0);
    checkOutput("sq_taken", {15'b0, branchtaken}, 16'h0);
    checkOutput("sq_flags", {12'b0, flags}, 16'h0004);
    applyStimulus();
    checkOutput("resume_valid", {15'b0, validout}, 16'h1);
    checkOutput("resume_res", aluresult, 16'h0002);
    checkOutput("resume_flags", {12'b0, flags}, 16'h0000);

    // Shifts
    setAlu(4'd11, 16'h8001, 16'h0001);
    applyStimulus();
    checkOutput("sra_res", aluresult, 16'hC000);
    checkOutput("sra_flags", {12'b0, flags}, 16'h000A);
    setAlu(4'd9, 16'h8001, 16'h0004);
    applyStimulus();
    checkOutput("rol_res", aluresult, 16'h0018);
    checkOutput("rol_flags", {12'b0, flags}, 16'h0000);
    setAlu(4'd8, 16'h8001, 16'h0001);
    applyStimulus();
    checkOutput("sll_res", aluresult, 16'h0002);
    checkOutput("sll_flags", {12'b0, flags}, 16'h0002);

    // SUB with borrow, ADD wrapping to zero
    setAlu(4'd1, 16'h0001, 16'h0002);
    applyStimulus();
    checkOutput("sub_res", aluresult, 16'hFFFF);
    checkOutput("sub_flags", {12'b0, flags}, 16'h000A);
    setAlu(4'd0, 16'hFFFF, 16'h0001);
    applyStimulus();
    checkOutput("addwrap_res", aluresult, 16'h0000);
    checkOutput("addwrap_flags", {12'b0, flags}, 16'h0006);

    // OUT then a load
    setAlu(4'd13, 16'h1234, 16'h0000); writereg = 1'b0;
    applyStimulus();
    checkOutput("out_port", outport, 16'h1234);
    checkOutput("out_valid", {15'b0, outvalid}, 16'h1);
    checkOutput("out_res", aluresult, 16'h0);
    checkOutput("out_flags", {12'b0, flags}, 16'h0006);
    setAlu(4'd0, 16'h0005, 16'h0005);
    memwrite = 2'b01; address = 16'hABCD; storedata = 16'h55AA; regaddress = 3'd6;
    applyStimulus();
    checkOutput("ld_res", aluresult, 16'h0);
    checkOutput("ld_mw", {14'b0, memwriteout}, 16'h1);
    checkOutput("ld_addr", addressout, 16'hABCD);
    checkOutput("ld_sdata", storedataout, 16'h55AA);
    checkOutput("ld_rega", {13'b0, regaddressout}, 16'h6);
    checkOutput("ld_flags", {12'b0, flags}, 16'h0006);
    checkOutput("ld_outvalid", {15'b0, outvalid}, 16'h0);
    checkOutput("ld_outport", outport, 16'h1234);

    // Halt together with an always-taken branch
    clearInputs();
    validin = 1'b1; haltin = 1'b1; isbranch = 1'b1; cond = 3'd4; writereg = 1'b1;
    applyStimulus();
    checkOutput("halt_out", {15'b0, haltout}, 16'h1);
    checkOutput("halt_valid", {15'b0, validout}, 16'h1);
    checkOutput("halt_wr", {15'b0, writeregout}, 16'h0);
    checkOutput("halt_taken", {15'b0, branchtaken}, 16'h0);
    setAlu(4'd0, 16'h0001, 16'h0001);
    applyStimulus();
    checkOutput("halted_valid", {15'b0, validout}, 16'h0);
    checkOutput("halted_sticky", {15'b0, haltout}, 16'h1);
    reset = 1'b1;
    applyStimulus();
    checkOutput("rst2_halt", {15'b0, haltout}, 16'h0);
    checkOutput("rst2_flags", {12'b0, flags}, 16'h0);
    checkOutput("rst2_outport", outport, 16'h0);

    // Reset while a taken branch is on the outputs clears the squash
    reset = 1'b0;
    clearInputs();
    validin = 1'b1; isbranch = 1'b1; cond = 3'd4; address = 16'hFFFF; pcin = 16'h0002;
    applyStimulus();
    checkOutput("br2_taken", {15'b0, branchtaken}, 16'h1);
    checkOutput("br2_target", branchtarget, 16'h0001);
    reset = 1'b1;
    applyStimulus();
    checkOutput("rst3_taken", {15'b0, branchtaken}, 16'h0);
    checkOutput("rst3_valid", {15'b0, validout}, 16'h0);
    reset = 1'b0;
    setAlu(4'd0, 16'h0002, 16'h0003);
    applyStimulus();
    checkOutput("post_rst_valid", {15'b0, validout}, 16'h1);
    checkOutput("post_rst_res", aluresult, 16'h0005);

    clearInputs();
    applyStimulus();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/p3_execute.md
P3_EXECUTE -- requirements
Module: p3_execute

Interface
REQ-001 SHALL have port clockp3  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  in  1  synchronous, active-high; sampled on the rising edge of clockp3.
REQ-003 SHALL have inputs validin 1, alu1 16, alu2 16, opcode 4, writereg 1, memwrite 2, regaddress 3, address 16, storedata 16, isbranch 1, cond 3, pcin 16, haltin 1; all are decode-stage outputs, sampled every edge.
REQ-004 SHALL have outputs validout 1, aluresult 16, writeregout 1, memwriteout 2, regaddressout 3, addressout 16, storedataout 16; all registered.
REQ-005 SHALL have outputs branchtaken 1, branchtarget 16, flags 4 {S,Z,C,V}, outport 16, outvalid 1, haltout 1; all registered.

Function
REQ-006 SHALL accept an input on an edge only if validin=1, haltout=0, no squash is pending, and reset=0.
REQ-007 SHALL have a latency of one edge: results of an accepted input appear on the outputs after that same edge.
REQ-008 SHALL drive validout=0 after a non-accepted edge, with writeregout=0, memwriteout=00, branchtaken=0, outvalid=0, and flags held.
REQ-009 SHALL compute aluresult by opcode: 0 ADD a1+a2; 1 SUB a1-a2; 2 AND; 3 OR; 4 XOR; 5 CMP a1-a2 (result discarded, 0 output); 6 MOV a1.
REQ-010 SHALL compute further opcodes: 8 SLL; 9 SLR (rotate left); 10 SRL; 11 SRA; shift amount alu2[3:0], 0..15; 12 IN gives 0; 13 OUT gives 0; others give 0.
REQ-011 SHALL wrap all arithmetic modulo 2^16.
REQ-012 SHALL set S=result[15] and Z=(result==0) for ADD/SUB/CMP.
REQ-013 SHALL set C=carry-out for ADD; C=borrow (a1<a2 unsigned) for SUB/CMP; V=signed overflow.
REQ-014 SHALL set S/Z from the result for AND/OR/XOR/MOV, with C=0 and V=0.
REQ-015 SHALL set S/Z from the result for shifts, with C=last bit shifted out (0 if amount=0) and V=0.
REQ-016 SHALL leave flags unchanged for opcodes 12-15, when memwrite≠00, and when isbranch=1.
REQ-017 SHALL, when memwrite≠00, drive aluresult=0 and pass memwrite, address, storedata and regaddress through unchanged.
REQ-018 SHALL, when memwrite=00, pass writereg and regaddress through and drive memwriteout=00.
REQ-019 SHALL evaluate a branch (isbranch=1) against flags before the current edge's update, by cond: 0 Z; 1 S^V; 2 Z|(S^V); 3 !Z; 4 always; other values never.
REQ-020 SHALL, for a branch, drive writeregout=0, branchtaken=condition, and branchtarget=pcin+address (wrap).
REQ-021 SHALL reject the single input presented on the edge immediately after branchtaken=1 (squash) and then resume acceptance; back-to-back taken branches cannot occur.
REQ-022 SHALL, for opcode 13 (OUT) accepted, load outport=alu1 and pulse outvalid=1 for one cycle; outport holds otherwise.
REQ-023 SHALL, when haltin=1 is accepted, set haltout=1 sticky until reset, drive validout=1 with writeregout=0, and reject all later inputs.
REQ-024 SHALL, when haltin and isbranch arrive together, give halt priority (branchtaken=0).

Reset
REQ-025 SHALL, on reset=1 at an edge, clear every output and internal state to 0, including flags=0000, haltout=0, outport=0 and the squash flag, regardless of an in-flight input, which is dropped.
REQ-026 SHALL, in the first edge with reset=0, accept inputs normally.

Verification
REQ-027 SHALL cover: ADD a1=7FFF a2=0001 -> aluresult=8000, flags S=1 Z=0 C=0 V=1, writeregout=1.
REQ-028 SHALL cover: CMP a1=0003 a2=0003, then branch cond=0 address=0005 pcin=0010 -> flags Z=1 C=0; branchtaken=1, target=0015; next input squashed (validout=0).
REQ-029 SHALL cover: SRA a1=8001 a2=0001 -> aluresult=C000, C=1, S=1; SLR a1=8001 a2=0004 -> 0018.
REQ-030 SHALL cover: OUT a1=1234 -> outport=1234, outvalid one cycle; then a load memwrite=01 -> flags unchanged, aluresult=0.
REQ-031 SHALL cover: haltin=1 -> haltout=1; following ADD ignored (validout=0); reset -> haltout=0, flags=0000.
REQ-032 SHALL cover: reset asserted in the same cycle as a taken branch -> branchtaken=0 after the edge; the next input is accepted (no squash).
